// File: rtl/dm_pkg.sv
// Shared colour encodings, the buffered-command record and pending-slot states
// for the dotmatrix_anim_scan driver.
package dm_pkg;

    // {green, red} enables
    typedef enum logic [1:0] {
        OFF    = 2'b00,
        RED    = 2'b01,
        GREEN  = 2'b10,
        YELLOW = 2'b11
    } color_e;

    // Fields are wide enough for any sensible TRACKS / COLS; the top narrows them.
    localparam int CMD_FIELD_W = 8;

    typedef struct packed {
        logic [CMD_FIELD_W-1:0] track;
        logic [CMD_FIELD_W-1:0] pos;
        color_e                 color;
        logic                   auto_adv;
    } dm_cmd_t;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_HELD,
        ST_APPLIED
    } pend_state_e;

endpackage

// File: rtl/dm_tick_gen.sv
// Two-stage divider: o_scan_tick every SCAN_DIV clks, o_frame_tick on every
// FRAME_DIV-th scan tick. Both are single-clk pulses.
module dm_tick_gen #(
    parameter int SCAN_DIV  = 1,
    parameter int FRAME_DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    output logic o_scan_tick,
    output logic o_frame_tick
);

    localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int FW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [SW-1:0] S_MAX = SW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] F_MAX = FW'(FRAME_DIV - 1);

    logic [SW-1:0] r_scan_cnt;
    logic [FW-1:0] r_frame_cnt;

    assign o_scan_tick  = (r_scan_cnt == S_MAX);
    assign o_frame_tick = o_scan_tick && (r_frame_cnt == F_MAX);

    // NOTE: sequential state uses <= so every register samples pre-edge values
    // regardless of the order the simulator evaluates processes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt  <= '0;
            r_frame_cnt <= '0;
        end else if (o_scan_tick) begin
            r_scan_cnt  <= '0;
            r_frame_cnt <= (r_frame_cnt == F_MAX) ? '0 : r_frame_cnt + 1'b1;
        end else begin
            r_scan_cnt  <= r_scan_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dotmatrix_anim_scan.sv
// Multiplexed bi-colour dot-matrix driver: each track owns two rows showing a
// two-column bar. Define DM_GHOST_BLANK_EN to blank one clk after each row change.
module dotmatrix_anim_scan
    import dm_pkg::*;
#(
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int TRACKS    = 3,
    parameter int SCAN_DIV  = 1,
    parameter int FRAME_DIV = 1000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [$clog2(TRACKS)-1:0]   cmd_track,
    input  logic [$clog2(COLS/2)-1:0]   cmd_pos,
    input  logic [1:0]                  cmd_color,
    input  logic                        cmd_auto,
    output logic                        cmd_err,
    output logic [ROWS-1:0]             row,
    output logic [COLS-1:0]             colr,
    output logic [COLS-1:0]             colg
);

    localparam int POS_W = $clog2(COLS/2);
    localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(ROWS - 1);
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(COLS/2 - 1);
    localparam logic [COLS-1:0]  PAT_TOP = {2'b11, {(COLS-2){1'b0}}};

    logic w_scan_tick;
    logic w_frame_tick;

    pend_state_e r_state, w_state_nxt;
    dm_cmd_t     r_pend;
    logic        w_track_ok, w_load, w_apply, w_reject;
    logic        r_err;

    logic [POS_W-1:0] r_pos   [TRACKS];
    logic [1:0]       r_color [TRACKS];
    logic             r_auto  [TRACKS];

    logic [IDX_W-1:0] r_idx, w_idx_sel;
    logic [ROWS-1:0]  r_row, w_row_nxt;
    logic [COLS-1:0]  r_colr, r_colg, w_colr_nxt, w_colg_nxt, w_pat;

    dm_tick_gen #(
        .SCAN_DIV  (SCAN_DIV),
        .FRAME_DIV (FRAME_DIV)
    ) u_tick_gen (
        .clk          (clk),
        .rst_n        (rst_n),
        .o_scan_tick  (w_scan_tick),
        .o_frame_tick (w_frame_tick)
    );

    assign w_track_ok = int'(cmd_track) < TRACKS;

    // NOTE: every always_comb output gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_apply     = 1'b0;
        w_reject    = 1'b0;
        unique case (r_state)
            ST_EMPTY: begin
                if (cmd_valid) begin
                    if (w_track_ok) begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_HELD;
                    end else begin
                        w_reject    = 1'b1;
                    end
                end
            end
            ST_HELD: begin
                if (w_frame_tick) begin
                    w_apply     = 1'b1;
                    w_state_nxt = ST_APPLIED;
                end
            end
            ST_APPLIED: w_state_nxt = ST_EMPTY;
            default:    w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_pend  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_reject;
            if (w_load) begin
                r_pend <= '{track:    CMD_FIELD_W'(cmd_track),
                            pos:      CMD_FIELD_W'(cmd_pos),
                            color:    color_e'(cmd_color),
                            auto_adv: cmd_auto};
            end
        end
    end

    // NOTE: per-track state is a handful of flops, not a RAM, so resetting
    // every element is cheap and gives a defined display out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < TRACKS; t++) begin
                r_pos[t]   <= '0;
                r_color[t] <= RED;
                r_auto[t]  <= 1'b0;
            end
        end else if (w_frame_tick) begin
            for (int t = 0; t < TRACKS; t++) begin
                if (w_apply && int'(r_pend.track) == t) begin
                    r_pos[t]   <= POS_W'(r_pend.pos);
                    r_color[t] <= r_pend.color;
                    r_auto[t]  <= r_pend.auto_adv;
                end else if (r_auto[t]) begin
                    r_pos[t]   <= (r_pos[t] == POS_MAX) ? '0 : r_pos[t] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (w_scan_tick) begin
            r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
        end
    end

    // Rows 3t and 3t+1 belong to track t; the third row of each group is a spacer.
    always_comb begin
        w_row_nxt  = '1;
        w_colr_nxt = '0;
        w_colg_nxt = '0;
        w_pat      = '0;
        w_row_nxt[w_idx_sel] = 1'b0;
        for (int t = 0; t < TRACKS; t++) begin
            if (int'(w_idx_sel) == 3*t || int'(w_idx_sel) == 3*t + 1) begin
                w_pat      = PAT_TOP >> {r_pos[t], 1'b0};
                w_colr_nxt = w_pat & {COLS{r_color[t][0]}};
                w_colg_nxt = w_pat & {COLS{r_color[t][1]}};
            end
        end
    end

`ifdef DM_GHOST_BLANK_EN
    logic [IDX_W-1:0] r_show_idx;
    logic             r_unblank;

    assign w_idx_sel = r_show_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_show_idx <= '0;
            r_unblank  <= 1'b0;
            r_row      <= '1;
            r_colr     <= '0;
            r_colg     <= '0;
        end else if (w_scan_tick) begin
            r_show_idx <= r_idx;
            r_unblank  <= 1'b1;
            r_row      <= '1;
            r_colr     <= '0;
            r_colg     <= '0;
        end else if (r_unblank) begin
            r_unblank  <= 1'b0;
            r_row      <= w_row_nxt;
            r_colr     <= w_colr_nxt;
            r_colg     <= w_colg_nxt;
        end
    end
`else
    assign w_idx_sel = r_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row  <= '1;
            r_colr <= '0;
            r_colg <= '0;
        end else if (w_scan_tick) begin
            r_row  <= w_row_nxt;
            r_colr <= w_colr_nxt;
            r_colg <= w_colg_nxt;
        end
    end
`endif

    assign cmd_ready = (r_state == ST_EMPTY);
    assign cmd_err   = r_err;
    assign row       = r_row;
    assign colr      = r_colr;
    assign colg      = r_colg;

endmodule

// File: tb/tb_dotmatrix_anim_scan.sv
// Self-checking bench for dotmatrix_anim_scan (default build, no ghost blanking)
// against a cycle-level behavioural model of the scan/frame/command rules.
module tb_dotmatrix_anim_scan;

    localparam int ROWS      = 8;
    localparam int COLS      = 8;
    localparam int TRACKS    = 3;
    localparam int SCAN_DIV  = 1;
    localparam int FRAME_DIV = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_track;
    logic [1:0]      cmd_pos;
    logic [1:0]      cmd_color;
    logic            cmd_auto;
    logic            cmd_err;
    logic [ROWS-1:0] row;
    logic [COLS-1:0] colr;
    logic [COLS-1:0] colg;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int              m_n;
    int              m_pos   [TRACKS];
    logic [1:0]      m_color [TRACKS];
    bit              m_auto  [TRACKS];
    bit              m_pend, m_applied, m_acc;
    int              p_trk, p_pos;
    logic [1:0]      p_col;
    bit              p_auto;
    logic [ROWS-1:0] m_row;
    logic [COLS-1:0] m_colr, m_colg;
    logic            m_ready, m_err;

    dotmatrix_anim_scan #(
        .ROWS      (ROWS),
        .COLS      (COLS),
        .TRACKS    (TRACKS),
        .SCAN_DIV  (SCAN_DIV),
        .FRAME_DIV (FRAME_DIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_track (cmd_track),
        .cmd_pos   (cmd_pos),
        .cmd_color (cmd_color),
        .cmd_auto  (cmd_auto),
        .cmd_err   (cmd_err),
        .row       (row),
        .colr      (colr),
        .colg      (colg)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_n = 0;
        for (int t = 0; t < TRACKS; t++) begin
            m_pos[t]   = 0;
            m_color[t] = 2'b01;
            m_auto[t]  = 1'b0;
        end
        m_pend = 0; m_applied = 0; m_acc = 0;
        m_row = '1; m_colr = '0; m_colg = '0; m_ready = 1'b1; m_err = 1'b0;
    endtask

    // One clock edge: scan at SCAN_DIV=1 shows row (n-1)%ROWS after edge n;
    // edge n is a frame tick when n is a multiple of FRAME_DIV.
    task automatic step();
        int idx, t;
        bit was_pend, was_applied;
        logic [COLS-1:0] pat;
        @(posedge clk);
        m_n++;
        idx    = (m_n - 1) % ROWS;
        t      = idx / 3;
        m_row  = ~(ROWS'(1) << idx);
        m_colr = '0;
        m_colg = '0;
        if (idx % 3 != 2 && t < TRACKS) begin
            pat = COLS'(3) << (COLS - 2 - 2 * m_pos[t]);
            if (m_color[t][0]) m_colr = pat;
            if (m_color[t][1]) m_colg = pat;
        end
        was_pend    = m_pend;
        was_applied = m_applied;
        if (was_applied) begin
            m_pend    = 0;
            m_applied = 0;
        end
        if (m_n % FRAME_DIV == 0) begin
            for (int k = 0; k < TRACKS; k++)
                if (m_auto[k]) m_pos[k] = (m_pos[k] + 1) % (COLS / 2);
            if (m_pend && !was_applied) begin
                m_pos[p_trk]   = p_pos;
                m_color[p_trk] = p_col;
                m_auto[p_trk]  = p_auto;
                m_applied      = 1;
            end
        end
        m_acc = 0;
        m_err = 1'b0;
        if (cmd_valid && !was_pend) begin
            m_acc = 1;
            if (int'(cmd_track) >= TRACKS) begin
                m_err = 1'b1;
            end else begin
                m_pend = 1;
                p_trk  = int'(cmd_track);
                p_pos  = int'(cmd_pos);
                p_col  = cmd_color;
                p_auto = cmd_auto;
            end
        end
        m_ready = !m_pend;
        #1;
    endtask

    task automatic issue(input int trk, input int pos, input int col, input int au);
        int guard;
        guard     = 0;
        cmd_track = 2'(trk);
        cmd_pos   = 2'(pos);
        cmd_color = 2'(col);
        cmd_auto  = au[0];
        cmd_valid = 1'b1;
        do begin
            step();
            guard++;
        end while (!m_acc && guard < 4 * FRAME_DIV);
        cmd_valid = 1'b0;
        checks++;
        if (cmd_ready !== m_ready)
            $display("FAIL issue_accept trk=%0d got cmd_ready=%b exp=%b", trk, cmd_ready, m_ready);
        if (cmd_ready !== m_ready) failures++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_track = '0; cmd_pos = '0;
        cmd_color = '0; cmd_auto = 1'b0;
        model_reset();
        #12;
        checks++;
        if ({row, colr, colg, cmd_ready, cmd_err} !== {8'hFF, 8'h00, 8'h00, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset_state got=%h/%h/%h/%b/%b exp=ff/00/00/1/0",
                     row, colr, colg, cmd_ready, cmd_err);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();
        checks++;
        if (row !== 8'hFE) begin
            failures++;
            $display("FAIL reset_first_row got=%h exp=fe", row);
        end
    endtask

    task automatic test_scan();
        for (int i = 0; i < 2 * ROWS + 2; i++) begin
            step();
            checks++;
            if ({row, colr, colg, cmd_ready, cmd_err} !== {m_row, m_colr, m_colg, m_ready, m_err}) begin
                failures++;
                $display("FAIL scan n=%0d got=%h exp=%h", m_n,
                         {row, colr, colg, cmd_ready, cmd_err}, {m_row, m_colr, m_colg, m_ready, m_err});
            end
            if ((m_n - 1) % ROWS < 2) begin
                checks++;
                if (colr !== 8'hC0 || colg !== 8'h00) begin
                    failures++;
                    $display("FAIL scan_track0 n=%0d got r=%h g=%h exp r=c0 g=00", m_n, colr, colg);
                end
            end
        end
    endtask

    task automatic test_command();
        issue(1, 2, 3, 0);
        checks++;
        if (cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL cmd_ready_held got=%b exp=0", cmd_ready);
        end
        for (int i = 0; i < 4 * FRAME_DIV && m_pend; i++) begin
            step();
            checks++;
            if ({row, colr, colg, cmd_ready, cmd_err} !== {m_row, m_colr, m_colg, m_ready, m_err}) begin
                failures++;
                $display("FAIL cmd_wait n=%0d got=%h exp=%h", m_n,
                         {row, colr, colg, cmd_ready, cmd_err}, {m_row, m_colr, m_colg, m_ready, m_err});
            end
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL cmd_apply_timeout got cmd_ready=%b exp=1", cmd_ready);
        end
        for (int i = 0; i < ROWS + 1; i++) begin
            step();
            checks++;
            if ({row, colr, colg, cmd_ready, cmd_err} !== {m_row, m_colr, m_colg, m_ready, m_err}) begin
                failures++;
                $display("FAIL cmd_show n=%0d got=%h exp=%h", m_n,
                         {row, colr, colg, cmd_ready, cmd_err}, {m_row, m_colr, m_colg, m_ready, m_err});
            end
            if ((m_n - 1) % ROWS == 3 || (m_n - 1) % ROWS == 4) begin
                checks++;
                if (colr !== 8'h0C || colg !== 8'h0C) begin
                    failures++;
                    $display("FAIL cmd_track1 n=%0d got r=%h g=%h exp r=0c g=0c", m_n, colr, colg);
                end
            end
        end
    endtask

    task automatic test_auto_wrap();
        issue(2, 3, 1, 1);
        for (int i = 0; i < 4 * FRAME_DIV && m_pend; i++) begin
            step();
            checks++;
            if ({row, colr, colg, cmd_ready, cmd_err} !== {m_row, m_colr, m_colg, m_ready, m_err}) begin
                failures++;
                $display("FAIL wrap_wait n=%0d got=%h exp=%h", m_n,
                         {row, colr, colg, cmd_ready, cmd_err}, {m_row, m_colr, m_colg, m_ready, m_err});
            end
        end
        for (int i = 0; i < 2 * FRAME_DIV && (m_n % FRAME_DIV) != 0; i++) step();
        for (int i = 0; i < ROWS + 1; i++) begin
            step();
            checks++;
            if ({row, colr, colg, cmd_ready, cmd_err} !== {m_row, m_colr, m_colg, m_ready, m_err}) begin
                failures++;
                $display("FAIL wrap_show n=%0d got=%h exp=%h", m_n,
                         {row, colr, colg, cmd_ready, cmd_err}, {m_row, m_colr, m_colg, m_ready, m_err});
            end
            if ((m_n - 1) % ROWS >= 6) begin
                checks++;
                if (colr !== 8'hC0 || colg !== 8'h00) begin
                    failures++;
                    $display("FAIL wrap_track2 n=%0d got r=%h g=%h exp r=c0 g=00", m_n, colr, colg);
                end
            end
        end
    endtask

    task automatic test_conflict();
        issue(0, 1, 1, 1);
        for (int i = 0; i < 4 * FRAME_DIV && m_pend; i++) step();
        issue(0, 3, 1, 0);
        for (int i = 0; i < 4 * FRAME_DIV && m_pend; i++) begin
            step();
            checks++;
            if ({row, colr, colg, cmd_ready, cmd_err} !== {m_row, m_colr, m_colg, m_ready, m_err}) begin
                failures++;
                $display("FAIL conflict_wait n=%0d got=%h exp=%h", m_n,
                         {row, colr, colg, cmd_ready, cmd_err}, {m_row, m_colr, m_colg, m_ready, m_err});
            end
        end
        for (int i = 0; i < ROWS + 1; i++) begin
            step();
            if ((m_n - 1) % ROWS < 2) begin
                checks++;
                if (colr !== 8'h03 || colg !== 8'h00) begin
                    failures++;
                    $display("FAIL conflict_track0 n=%0d got r=%h g=%h exp r=03 g=00", m_n, colr, colg);
                end
            end
        end
    endtask

    task automatic test_back_to_back_err();
        cmd_track = 2'd3; cmd_pos = 2'd1; cmd_color = 2'b10; cmd_auto = 1'b1;
        cmd_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (cmd_err !== 1'b1 || cmd_ready !== 1'b1) begin
                failures++;
                $display("FAIL err_pulse i=%0d got err=%b ready=%b exp err=1 ready=1", i, cmd_err, cmd_ready);
            end
        end
        cmd_valid = 1'b0;
        step();
        checks++;
        if (cmd_err !== 1'b0) begin
            failures++;
            $display("FAIL err_clear got=%b exp=0", cmd_err);
        end
        for (int i = 0; i < FRAME_DIV + ROWS; i++) begin
            step();
            checks++;
            if ({row, colr, colg, cmd_ready, cmd_err} !== {m_row, m_colr, m_colg, m_ready, m_err}) begin
                failures++;
                $display("FAIL err_display n=%0d got=%h exp=%h", m_n,
                         {row, colr, colg, cmd_ready, cmd_err}, {m_row, m_colr, m_colg, m_ready, m_err});
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2 * FRAME_DIV && (m_n % FRAME_DIV) != 1; i++) step();
        issue(1, 1, 3, 1);
        repeat (3) step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({row, colr, colg, cmd_ready, cmd_err} !== {8'hFF, 8'h00, 8'h00, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset_mid got=%h/%h/%h/%b/%b exp=ff/00/00/1/0",
                     row, colr, colg, cmd_ready, cmd_err);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 2 * FRAME_DIV + ROWS; i++) begin
            step();
            checks++;
            if ({row, colr, colg, cmd_ready, cmd_err} !== {m_row, m_colr, m_colg, m_ready, m_err}) begin
                failures++;
                $display("FAIL reset_mid_run n=%0d got=%h exp=%h", m_n,
                         {row, colr, colg, cmd_ready, cmd_err}, {m_row, m_colr, m_colg, m_ready, m_err});
            end
            if (m_n > FRAME_DIV && (m_n - 1) % ROWS == 3) begin
                checks++;
                if (colr !== 8'hC0 || colg !== 8'h00) begin
                    failures++;
                    $display("FAIL reset_mid_discard n=%0d got r=%h g=%h exp r=c0 g=00", m_n, colr, colg);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            cmd_valid = ($urandom_range(0, 3) == 0);
            cmd_track = 2'($urandom_range(0, 3));
            cmd_pos   = 2'($urandom_range(0, 3));
            cmd_color = 2'($urandom_range(0, 3));
            cmd_auto  = 1'($urandom_range(0, 1));
            step();
            checks++;
            if ({row, colr, colg, cmd_ready, cmd_err} !== {m_row, m_colr, m_colg, m_ready, m_err}) begin
                failures++;
                $display("FAIL random n=%0d got=%h exp=%h", m_n,
                         {row, colr, colg, cmd_ready, cmd_err}, {m_row, m_colr, m_colg, m_ready, m_err});
            end
        end
        cmd_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_command();
        test_auto_wrap();
        test_conflict();
        test_back_to_back_err();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
